x_23k640_model: RTL
===================

// Module: x_23K640_model
// PURPOSE
//  Synthesisable SPI responder emulating one 23K640 serial SRAM (mode 0; READ/WRITE/RDSR/WRSR).
//  Sits on the far side of the SCK/CS/SO/SI pins of the SRAM drivers.
//  Used on-FPGA and in benches as a loop-back target for the 16-channel SPI SRAM test harness.
//  Backed by an inferred block-RAM array; all logic runs on one clock, i_clk.
// PARAMETERS
//  p_addr_w     13   implemented address bits; the upper bits of the 16-bit address field are ignored
//  p_page_w     5    page-offset bits; page = 2**p_page_w bytes (32)
//  p_sync       2    synchroniser depth on i_sck/i_cs/i_si (>=2)
// PORTS
//  i_clk     in   1  system clock
//  i_rst     in   1  asynchronous active-low reset
//  i_sck     in   1  SPI clock from initiator; idle low
//  i_cs      in   1  chip select, active low
//  i_si      in   1  serial data from initiator (driver o_so)
//  o_so      out  1  serial data to initiator (driver i_si)
//  o_so_oe   out  1  1 while o_so carries valid read/status data
//  o_status  out  8  current status register (debug)
// BEHAVIOUR
//  Reset (i_rst=0, async): o_so=0, o_so_oe=0, o_status=8'h02, FSM=IDLE, bit counter=0.
//  - Memory contents are not reset.
//  Sampling:
//  - i_sck, i_cs, i_si pass through p_sync flops.
//  - rise/fall = edge detect on synchronised sck.
//  - Requirement on initiator: SCK high and low phases >= p_sync+2 i_clk cycles each.
//  - SI sampled on sck rise; o_so updated on sck fall, MSB first.
//  - Synchronised cs high: FSM->IDLE next cycle, o_so_oe=0, o_so=0; partial byte and any pending op discarded.
//  FSM states: IDLE, CMD, ADDR, RDATA, WDATA, RDSR, WRSR, IGNORE.
//  - IDLE->CMD: cs falls.
//  - CMD: 8 rises. 8'h03/8'h02 -> ADDR; 8'h05 -> RDSR; 8'h01 -> WRSR; any other -> IGNORE until cs high.
//  - ADDR: 16 rises; addr = field[p_addr_w-1:0]. Then READ -> RDATA, WRITE -> WDATA.
//  - RDATA: array read issued on the 24th rise, completes before the next fall.
//    - Data bit7 driven on that fall; o_so_oe=1 from that fall.
//  - WDATA: byte written to array on the cycle after each 8th data rise.
//  - RDSR: status bit7 driven on the fall after the 8th command rise; repeats status every 8 bits.
//  - WRSR: on 8th data rise, status[7:6]<=si[7:6], status[0]<=si[0]; status[1]=1; others 0.
//    - Further bytes ignored.
//  Modes (status[7:6]):
//  - 00 byte: one data byte per cs window; further READ clocks drive o_so=0, further WRITE bytes dropped.
//  - 10 page: addr increments after each byte; the low p_page_w bits wrap, the upper bits are fixed.
//  - 01 sequential: addr increments and wraps 2**p_addr_w-1 -> 0.
//  - 11: treated as byte mode.
//  Address increment for a read happens after the 8th bit is shifted, so the next byte streams without a gap.
//  cs high mid data byte: write of that byte suppressed; earlier complete bytes remain written.
//  Simultaneous sck edge and cs deassert in the same cycle: cs wins (edge ignored).
//  Reset mid-transaction: all state returns to reset values immediately; the array is untouched.
// TESTING
//  1. Reset, RDSR (05) -> 8'h02 on o_so, o_so_oe=1 during data; cs high -> o_so_oe=0 within p_sync+1 cycles.
//  2. Byte mode: WRITE 02 0010 A5, then READ 03 0010 -> A5.
//     - A 2nd byte written in the same window is absent at 0x0011 (retains prior value).
//  3. WRSR 01 80 (page); WRITE from 0x001E with 11 22 33 44 -> 0x1E=11, 0x1F=22, 0x00=33, 0x01=44;
//     - read-back in page mode wraps identically.
//  4. WRSR 01 40 (seq); WRITE at 0x1FFF with 5A C3 -> 0x1FFF=5A, 0x0000=C3; READ 03 1FFF x2 bytes -> 5A C3.
//  5. Unknown cmd 8'hFF plus 24 clocks -> o_so_oe stays 0, memory and status unchanged.
//     - cs pulled high after 4 data bits of a WRITE -> target byte unchanged.
//  6. Assert i_rst mid READ at bit 3 -> o_so=0, o_so_oe=0, status=02 asynchronously; previously written data still reads back.

Source files
------------

// File: rtl/x_23k640_model.sv
// x_23k640_model: SPI mode-0 responder emulating a 23K640 serial SRAM (READ/WRITE/RDSR/WRSR).
// SPI pins are oversampled on i_clk; i_rst is an asynchronous active-low reset.
module x_23k640_model #(
    parameter int p_addr_w = 13,
    parameter int p_page_w = 5,
    parameter int p_sync   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sck,
    input  logic       i_cs,
    input  logic       i_si,
    output logic       o_so,
    output logic       o_so_oe,
    output logic [7:0] o_status
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, RDSR, WRSR, IGNORE} state_t;
    state_t state;
    logic [p_sync-1:0] sck_q, cs_q, si_q;
    logic sck_s, cs_s, si_s, sck_d, rise, fall;
    logic [15:0] sh, sh_n;
    logic [3:0] cnt;
    logic is_rd, done, we, byte_mode;
    logic [7:0] tx, wdata, rd_q, ld;
    logic [p_addr_w-1:0] addr, waddr, addr_nx;
    logic [p_page_w-1:0] pg_nx;
    logic [7:0] mem [0:2**p_addr_w-1];
    always_comb begin
        sck_s = sck_q[p_sync-1];
        cs_s = cs_q[p_sync-1];
        si_s = si_q[p_sync-1];
        rise = sck_s & ~sck_d;
        fall = ~sck_s & sck_d;
        sh_n = {sh[14:0], si_s};
        byte_mode = o_status[7] == o_status[6];
        pg_nx = addr[p_page_w-1:0] + 1'b1;
        addr_nx = o_status[7] ? {addr[p_addr_w-1:p_page_w], pg_nx} : addr + 1'b1;
        ld = state == RDSR ? o_status : done ? 8'h00 : rd_q;
    end
    // Array has no reset; the read port follows addr so data is ready well before the next SCK fall.
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[addr];
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sck_q <= '0;
            cs_q <= '1;
            si_q <= '0;
            sck_d <= 1'b0;
            state <= IDLE;
            sh <= '0;
            cnt <= '0;
            is_rd <= 1'b0;
            done <= 1'b0;
            tx <= '0;
            addr <= '0;
            waddr <= '0;
            wdata <= '0;
            we <= 1'b0;
            o_so <= 1'b0;
            o_so_oe <= 1'b0;
            o_status <= 8'h02;
        end else begin
            sck_q <= {sck_q[p_sync-2:0], i_sck};
            cs_q <= {cs_q[p_sync-2:0], i_cs};
            si_q <= {si_q[p_sync-2:0], i_si};
            sck_d <= sck_s;
            we <= 1'b0;
            if (cs_s) begin
                state <= IDLE;
                cnt <= '0;
                done <= 1'b0;
                o_so <= 1'b0;
                o_so_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                        cnt <= '0;
                    end
                    CMD: if (rise) begin
                        sh <= sh_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == 4'd7) begin
                            cnt <= '0;
                            is_rd <= sh_n[7:0] == 8'h03;
                            state <= (sh_n[7:0] == 8'h03 || sh_n[7:0] == 8'h02) ? ADDR :
                                     sh_n[7:0] == 8'h05 ? RDSR :
                                     sh_n[7:0] == 8'h01 ? WRSR : IGNORE;
                        end
                    end
                    ADDR: if (rise) begin
                        sh <= sh_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == 4'd15) begin
                            cnt <= '0;
                            addr <= sh_n[p_addr_w-1:0];
                            state <= is_rd ? RDATA : WDATA;
                        end
                    end
                    RDATA, RDSR: begin
                        if (rise) begin
                            cnt <= cnt == 4'd7 ? 4'd0 : cnt + 1'b1;
                            if (cnt == 4'd7 && state == RDATA) begin
                                if (byte_mode) done <= 1'b1;
                                else addr <= addr_nx;
                            end
                        end
                        if (fall) begin
                            o_so_oe <= 1'b1;
                            o_so <= cnt == 4'd0 ? ld[7] : tx[7];
                            tx <= cnt == 4'd0 ? {ld[6:0], 1'b0} : {tx[6:0], 1'b0};
                        end
                    end
                    WDATA: if (rise) begin
                        sh <= sh_n;
                        cnt <= cnt == 4'd7 ? 4'd0 : cnt + 1'b1;
                        if (cnt == 4'd7) begin
                            we <= ~done;
                            wdata <= sh_n[7:0];
                            waddr <= addr;
                            if (byte_mode) done <= 1'b1;
                            else addr <= addr_nx;
                        end
                    end
                    WRSR: if (rise) begin
                        sh <= sh_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == 4'd7) begin
                            o_status <= {sh_n[7:6], 4'b0000, 1'b1, sh_n[0]};
                            state <= IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
